// File: rtl/set_bit_iterator_pkg.sv
// -----------------------------------------------------------------------------
// set_bit_iterator_pkg
//   Shared types and helpers for the set-bit iterator.
//   - state_t   : controller states (IDLE waits for a vector, EMIT streams beats)
//   - idx_width : width of a binary index into a WIDTH-bit vector
// -----------------------------------------------------------------------------
package set_bit_iterator_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  function automatic int unsigned idx_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/set_bit_iterator_bit_isolate.sv
// -----------------------------------------------------------------------------
// bit_isolate
//   Purely combinational: picks the lowest (msb_first=0) or highest
//   (msb_first=1) set bit of vec.
//   Ports:
//     vec       in  WIDTH  vector to scan
//     msb_first in  1      0 = lowest set bit, 1 = highest set bit
//     onehot    out WIDTH  one-hot mask of the chosen bit (0 when vec==0)
//     idx       out IDX_W  binary index of the chosen bit (0 when vec==0)
//     multi     out 1      more than one bit of vec is set
//     zero      out 1      vec is all-zero
// -----------------------------------------------------------------------------
module bit_isolate
  import set_bit_iterator_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned IDX_W = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  input  logic             msb_first,
  output logic [WIDTH-1:0] onehot,
  output logic [IDX_W-1:0] idx,
  output logic             multi,
  output logic             zero
);

  logic [IDX_W-1:0] lo_idx;
  logic [IDX_W-1:0] hi_idx;

  // Ascending scan: the last hit is the highest set bit.
  // Descending scan: the last hit is the lowest set bit.
  always_comb begin
    lo_idx = '0;
    hi_idx = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (vec[i]) hi_idx = IDX_W'(i);
    end
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (vec[WIDTH-1-i]) lo_idx = IDX_W'(WIDTH-1-i);
    end
  end

  always_comb begin
    zero   = ~|vec;
    // Clearing the lowest set bit leaves something only if 2+ bits were set.
    multi  = |(vec & (vec - WIDTH'(1)));
    idx    = msb_first ? hi_idx : lo_idx;
    onehot = zero ? '0 : (WIDTH'(1) << idx);
  end

endmodule

// File: rtl/set_bit_iterator.sv
// -----------------------------------------------------------------------------
// set_bit_iterator
//   Accepts one WIDTH-bit request vector per transaction and serialises it
//   into one beat per set bit (LSB-first or MSB-first, chosen per vector).
//   An all-zero vector produces a single empty beat.
//   Ports:
//     clk_i     in  1      clock, rising edge
//     srst_i    in  1      asynchronous active-high reset
//     data_i    in  WIDTH  request vector, sampled on accept
//     dir_i     in  1      0 = LSB first, 1 = MSB first, sampled on accept
//     valid_i   in  1      upstream vector valid
//     ready_o   out 1      block can accept a vector (IDLE)
//     onehot_o  out WIDTH  one-hot mask of the current set bit
//     idx_o     out IDX_W  binary index of the current set bit
//     valid_o   out 1      beat valid
//     last_o    out 1      final beat of the transaction
//     empty_o   out 1      accepted vector was all-zero
//     ready_i   in  1      downstream accepts the current beat
// -----------------------------------------------------------------------------
module set_bit_iterator
  import set_bit_iterator_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned IDX_W = idx_width(WIDTH)
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             dir_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] onehot_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o,
  output logic             last_o,
  output logic             empty_o,
  input  logic             ready_i
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;

  logic [WIDTH-1:0] iso_onehot;
  logic [IDX_W-1:0] iso_idx;
  logic             iso_multi;
  logic             iso_zero;

  // Beat outputs decode registered state only, so no input reaches them
  // combinationally.
  bit_isolate #(
    .WIDTH (WIDTH)
  ) u_isolate (
    .vec       (rem_q),
    .msb_first (dir_q),
    .onehot    (iso_onehot),
    .idx       (iso_idx),
    .multi     (iso_multi),
    .zero      (iso_zero)
  );

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state_q <= IDLE;
      rem_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    dir_d    = dir_q;
    ready_o  = 1'b0;
    valid_o  = 1'b0;
    onehot_o = '0;
    idx_o    = '0;
    last_o   = 1'b0;
    empty_o  = 1'b0;

    unique case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          rem_d   = data_i;
          dir_d   = dir_i;
          state_d = EMIT;
        end
      end

      EMIT: begin
        valid_o  = 1'b1;
        onehot_o = iso_onehot;
        idx_o    = iso_idx;
        last_o   = ~iso_multi;
        empty_o  = iso_zero;
        if (ready_i) begin
          if (iso_multi) begin
            rem_d = rem_q & ~iso_onehot;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_set_bit_iterator.sv
module tb_set_bit_iterator;

  logic       clk_i = 1'b0;
  logic       srst_i;
  logic [7:0] data_i;
  logic       dir_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] onehot_o;
  logic [2:0] idx_o;
  logic       valid_o;
  logic       last_o;
  logic       empty_o;
  logic       ready_i;

  int unsigned err_cnt = 0;
  int unsigned chk_cnt = 0;

  set_bit_iterator #(
    .WIDTH (8)
  ) dut (
    .clk_i    (clk_i),
    .srst_i   (srst_i),
    .data_i   (data_i),
    .dir_i    (dir_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .onehot_o (onehot_o),
    .idx_o    (idx_o),
    .valid_o  (valid_o),
    .last_o   (last_o),
    .empty_o  (empty_o),
    .ready_i  (ready_i)
  );

  // Rising edges at 5,15,25,...; falling edges at 10,20,...
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge while IDLE; accepted on the next rising edge.
  task automatic send(input logic [7:0] vec, input logic dir);
    data_i  = vec;
    dir_i   = dir;
    valid_i = 1'b1;
    @(posedge clk_i);
    #1 valid_i = 1'b0;
  endtask

  task automatic beat(input string tag, input logic [7:0] oh, input logic [2:0] idx,
                      input logic last, input logic empty);
    @(negedge clk_i);
    check({tag, ".valid"}, 32'(valid_o), 32'd1);
    check({tag, ".ready"}, 32'(ready_o), 32'd0);
    check({tag, ".onehot"}, 32'(onehot_o), 32'(oh));
    check({tag, ".idx"}, 32'(idx_o), 32'(idx));
    check({tag, ".last"}, 32'(last_o), 32'(last));
    check({tag, ".empty"}, 32'(empty_o), 32'(empty));
  endtask

  task automatic idle(input string tag);
    @(negedge clk_i);
    check({tag, ".ready"}, 32'(ready_o), 32'd1);
    check({tag, ".valid"}, 32'(valid_o), 32'd0);
    check({tag, ".onehot"}, 32'(onehot_o), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    srst_i  = 1'b1;
    data_i  = 8'h00;
    dir_i   = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;

    // 1: reset values, then ready after release
    #2;
    check("rst.ready", 32'(ready_o), 32'd1);
    check("rst.valid", 32'(valid_o), 32'd0);
    check("rst.onehot", 32'(onehot_o), 32'd0);
    check("rst.idx", 32'(idx_o), 32'd0);
    check("rst.last", 32'(last_o), 32'd0);
    check("rst.empty", 32'(empty_o), 32'd0);
    @(negedge clk_i);
    srst_i = 1'b0;
    idle("post_rst");

    // 2: 1010_0100 LSB first
    send(8'b1010_0100, 1'b0);
    beat("t2b0", 8'h04, 3'd2, 1'b0, 1'b0);
    beat("t2b1", 8'h20, 3'd5, 1'b0, 1'b0);
    beat("t2b2", 8'h80, 3'd7, 1'b1, 1'b0);
    idle("t2idle");

    // 3: same vector MSB first
    send(8'b1010_0100, 1'b1);
    beat("t3b0", 8'h80, 3'd7, 1'b0, 1'b0);
    beat("t3b1", 8'h20, 3'd5, 1'b0, 1'b0);
    beat("t3b2", 8'h04, 3'd2, 1'b1, 1'b0);
    idle("t3idle");

    // 4: all-zero vector gives one empty beat
    send(8'h00, 1'b0);
    beat("t4b0", 8'h00, 3'd0, 1'b1, 1'b1);
    idle("t4idle");

    // 5: all ones with backpressure at idx 3 and input churn during EMIT
    send(8'hFF, 1'b0);
    for (int i = 0; i < 8; i++) begin
      beat($sformatf("t5b%0d", i), 8'(1 << i), 3'(i), 1'(i == 7), 1'b0);
      if (i == 3) begin
        ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
          data_i  = 8'h5A ^ 8'(k);
          dir_i   = 1'(k);
          valid_i = 1'(k % 2 == 0);
          @(negedge clk_i);
          check($sformatf("t5hold%0d.onehot", k), 32'(onehot_o), 32'h08);
          check($sformatf("t5hold%0d.idx", k), 32'(idx_o), 32'd3);
          check($sformatf("t5hold%0d.valid", k), 32'(valid_o), 32'd1);
          check($sformatf("t5hold%0d.ready", k), 32'(ready_o), 32'd0);
        end
        ready_i = 1'b1;
        data_i  = 8'h01;
        dir_i   = 1'b0;
        valid_i = 1'b1;
      end
    end
    // valid_i stayed high through EMIT; accept only happens after the bubble
    idle("t5idle");
    @(posedge clk_i);
    #1 valid_i = 1'b0;
    beat("t5next", 8'h01, 3'd0, 1'b1, 1'b0);
    idle("t5idle2");

    // 6: async reset during beat 2 of 0001_0110
    send(8'b0001_0110, 1'b0);
    beat("t6b0", 8'h02, 3'd1, 1'b0, 1'b0);
    beat("t6b1", 8'h04, 3'd2, 1'b0, 1'b0);
    #2 srst_i = 1'b1;
    #1;
    check("t6rst.valid", 32'(valid_o), 32'd0);
    check("t6rst.ready", 32'(ready_o), 32'd1);
    check("t6rst.onehot", 32'(onehot_o), 32'd0);
    check("t6rst.idx", 32'(idx_o), 32'd0);
    #1 srst_i = 1'b0;
    idle("t6idle");
    send(8'b0001_0110, 1'b1);
    beat("t6c0", 8'h10, 3'd4, 1'b0, 1'b0);
    beat("t6c1", 8'h04, 3'd2, 1'b0, 1'b0);
    beat("t6c2", 8'h02, 3'd1, 1'b1, 1'b0);
    idle("t6idle2");

    // Extremes reachable as single beats in the opposite direction
    send(8'h80, 1'b0);
    beat("msb_lsbfirst", 8'h80, 3'd7, 1'b1, 1'b0);
    idle("x0idle");
    send(8'h01, 1'b1);
    beat("lsb_msbfirst", 8'h01, 3'd0, 1'b1, 1'b0);
    idle("x1idle");

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
